// File: rtl/mips_pkg.sv
// mips_pkg: shared state, opcode and control-field encodings for the multicycle MIPS control path
package mips_pkg;
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_IWB     = 4'd10,
        S_JEX     = 4'd11,
        S_ORIEX   = 4'd12
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_ORI   = 2'b11;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pcwrite;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       iord;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       regdst;
        logic       memtoreg;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       branch;
    } ctrl_t;
endpackage

// File: rtl/mc_outdec.sv
// mc_outdec: combinational state -> raw control word decode (ORIEX only with MC_MAINDEC_ORI_EN)
module mc_outdec
    import mips_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);
    // Moore control word per state; unlisted fields and unreachable states stay 0
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.alusrcb = SRCB_FOUR;
                ctrl.irwrite = 1'b1;
                ctrl.pcwrite = 1'b1;
            end
            S_DECODE: ctrl.alusrcb = SRCB_IMMSH;
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
            end
            S_MEMRD: ctrl.iord = 1'b1;
            S_MEMWB: begin
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord     = 1'b1;
                ctrl.memwrite = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_RT;
                ctrl.aluop   = ALUOP_RTYPE;
            end
            S_RTYPEWB: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = PCSRC_ALUOUT;
                ctrl.branch  = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_IWB: ctrl.regwrite = 1'b1;
            S_JEX: begin
                ctrl.pcsrc   = PCSRC_JUMP;
                ctrl.pcwrite = 1'b1;
            end
`ifdef MC_MAINDEC_ORI_EN
            S_ORIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.aluop   = ALUOP_ORI;
            end
`endif
            default: ctrl = '0;
        endcase
    end
endmodule

// File: rtl/mc_maindec.sv
// mc_maindec: multicycle main-control FSM; ori support is built only with MC_MAINDEC_ORI_EN
module mc_maindec
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       memready,
    output logic       pcen,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       iord,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       regdst,
    output logic       memtoreg,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal
);
    state_t state, next, cur;
    ctrl_t  ctrl;
    logic   legal;

    // During reset the outputs present FETCH values so the datapath sees a clean start
    assign cur = reset ? S_FETCH : state;

    mc_outdec u_outdec (.state(cur), .ctrl(ctrl));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_FETCH;
        else       state <= next;
    end

    // Next-state selection and opcode legality check in DECODE
    always_comb begin
        next  = S_FETCH;
        legal = 1'b1;
        case (state)
            S_FETCH: next = memready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: next = S_MEMADR;
                    OP_RTYPE:     next = S_RTYPEEX;
                    OP_BEQ:       next = S_BEQEX;
                    OP_ADDI:      next = S_ADDIEX;
                    OP_J:         next = S_JEX;
`ifdef MC_MAINDEC_ORI_EN
                    OP_ORI:       next = S_ORIEX;
`endif
                    default:      legal = 1'b0;
                endcase
            end
            S_MEMADR:  next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   next = memready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   next = memready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: next = S_RTYPEWB;
            S_ADDIEX:  next = S_IWB;
`ifdef MC_MAINDEC_ORI_EN
            S_ORIEX:   next = S_IWB;
`endif
            default:   next = S_FETCH;
        endcase
    end

    // Fetch enables wait for memready; memwrite is held through the MEMWR stall
    assign irwrite  = ctrl.irwrite & memready & ~reset;
    assign pcen     = ~reset & ((ctrl.pcwrite & (memready | cur != S_FETCH)) | (ctrl.branch & zero));
    assign memwrite = ctrl.memwrite & ~reset;
    assign regwrite = ctrl.regwrite & ~reset;
    assign illegal  = ~legal & ~reset;
    assign iord     = ctrl.iord;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign regdst   = ctrl.regdst;
    assign memtoreg = ctrl.memtoreg;
    assign pcsrc    = ctrl.pcsrc;
    assign aluop    = ctrl.aluop;
endmodule

// File: tb/tb_mc_maindec.sv
// tb_mc_maindec: per-cycle check of mc_maindec against an instruction-level expected-cycle model
module tb_mc_maindec;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010, ORI = 6'b001101, BAD = 6'b111111;

    logic clk = 1'b0, reset, zero, memready;
    logic [5:0] op;
    logic pcen, memwrite, irwrite, regwrite, iord, alusrca, regdst, memtoreg, illegal;
    logic [1:0] alusrcb, pcsrc, aluop;
    int checks = 0, errors = 0;

    typedef struct {
        logic        mr;
        logic        z;
        logic [14:0] exp;
    } cyc_t;

    typedef struct {
        logic [5:0] op;
        int         fs;
        int         ms;
        logic       z;
        int         cycles;
    } vec_t;

    cyc_t q[$];
    vec_t tbl[$];

    mc_maindec dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .memready(memready),
        .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .iord(iord), .alusrca(alusrca), .alusrcb(alusrcb), .regdst(regdst),
        .memtoreg(memtoreg), .pcsrc(pcsrc), .aluop(aluop), .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic logic [14:0] v(logic pc, logic mw, logic irw, logic rw, logic io, logic asa,
                                      logic [1:0] asb, logic rd, logic m2r, logic [1:0] pcs,
                                      logic [1:0] aop, logic ill);
        return {pc, mw, irw, rw, io, asa, asb, rd, m2r, pcs, aop, ill};
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic is_legal(logic [5:0] o);
`ifdef MC_MAINDEC_ORI_EN
        if (o == ORI) return 1'b1;
`endif
        return o inside {LW, SW, RT, BEQ, ADDI, JMP};
    endfunction

    task automatic push(logic mr, logic z, logic [14:0] e);
        cyc_t c;
        c.mr = mr; c.z = z; c.exp = e;
        q.push_back(c);
    endtask

    // Expected cycle list for one instruction: fetch stalls fs, memory stalls ms
    task automatic build(input logic [5:0] o, input int fs, input int ms, input logic zb);
        for (int i = 0; i < fs; i++) push(1'b0, rb(), v(0,0,0,0,0,0,2'b01,0,0,2'b00,2'b00,0));
        push(1'b1, rb(), v(1,0,1,0,0,0,2'b01,0,0,2'b00,2'b00,0));
        push(rb(), rb(), v(0,0,0,0,0,0,2'b11,0,0,2'b00,2'b00,!is_legal(o)));
        if (!is_legal(o)) return;
        if (o == LW || o == SW) begin
            push(rb(), rb(), v(0,0,0,0,0,1,2'b10,0,0,2'b00,2'b00,0));
            for (int i = 0; i <= ms; i++)
                push(i == ms, rb(), v(0, o == SW, 0,0,1,0,2'b00,0,0,2'b00,2'b00,0));
            if (o == LW) push(rb(), rb(), v(0,0,0,1,0,0,2'b00,0,1,2'b00,2'b00,0));
        end else if (o == RT) begin
            push(rb(), rb(), v(0,0,0,0,0,1,2'b00,0,0,2'b00,2'b10,0));
            push(rb(), rb(), v(0,0,0,1,0,0,2'b00,1,0,2'b00,2'b00,0));
        end else if (o == BEQ) begin
            push(rb(), zb, v(zb,0,0,0,0,1,2'b00,0,0,2'b01,2'b01,0));
        end else if (o == JMP) begin
            push(rb(), rb(), v(1,0,0,0,0,0,2'b00,0,0,2'b10,2'b00,0));
        end else begin
            push(rb(), rb(), v(0,0,0,0,0,1,2'b10,0,0,2'b00, o == ORI ? 2'b11 : 2'b00, 0));
            push(rb(), rb(), v(0,0,0,1,0,0,2'b00,0,0,2'b00,2'b00,0));
        end
    endtask

    task automatic check(string name, logic [14:0] got, logic [14:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (pcen,mw,irw,rw,iord,asa,asb,rd,m2r,pcs,aop,ill)",
                     name, got, exp);
        end
    endtask

    task automatic run(string name);
        while (q.size() > 0) begin
            cyc_t c;
            c = q.pop_front();
            memready = c.mr;
            zero = c.z;
            @(negedge clk);
            check(name, {pcen, memwrite, irwrite, regwrite, iord, alusrca, alusrcb,
                         regdst, memtoreg, pcsrc, aluop, illegal}, c.exp);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic add(logic [5:0] o, int fs, int ms, logic z, int cyc);
        vec_t t;
        t.op = o; t.fs = fs; t.ms = ms; t.z = z; t.cycles = cyc;
        tbl.push_back(t);
    endtask

    initial begin
        logic [5:0] ops [8];
        ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = BEQ;
        ops[4] = ADDI; ops[5] = JMP; ops[6] = ORI; ops[7] = BAD;
        add(LW, 0, 0, 0, 5);
        add(LW, 0, 2, 0, 7);
        add(SW, 0, 0, 0, 4);
        add(SW, 0, 1, 0, 5);
        add(RT, 0, 0, 0, 4);
        add(BEQ, 0, 0, 1, 3);
        add(BEQ, 0, 0, 0, 3);
        add(ADDI, 0, 0, 0, 4);
        add(JMP, 0, 0, 0, 3);
`ifdef MC_MAINDEC_ORI_EN
        add(ORI, 0, 0, 0, 4);
`else
        add(ORI, 0, 0, 0, 2);
`endif
        add(BAD, 0, 0, 0, 2);
        add(LW, 1, 0, 0, 6);

        reset = 1'b1; memready = 1'b1; zero = 1'b1; op = RT;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_state", {pcen, memwrite, irwrite, regwrite, iord, alusrca, alusrcb,
                              regdst, memtoreg, pcsrc, aluop, illegal},
              v(0,0,0,0,0,0,2'b01,0,0,2'b00,2'b00,0));
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (tbl[i]) begin
            op = tbl[i].op;
            build(tbl[i].op, tbl[i].fs, tbl[i].ms, tbl[i].z);
            checks++;
            if (q.size() != tbl[i].cycles) begin
                errors++;
                $display("FAIL cycles[%0d]: got %0d expected %0d", i, q.size(), tbl[i].cycles);
            end
            run($sformatf("vec%0d_op%b", i, tbl[i].op));
        end

        // Reset held three cycles while sitting in RTYPEEX
        op = RT;
        build(RT, 0, 0, 0);
        void'(q.pop_back());
        void'(q.pop_back());
        run("pre_reset");
        reset = 1'b1;
        for (int i = 0; i < 3; i++) push(1'b1, 1'b1, v(0,0,0,0,0,0,2'b01,0,0,2'b00,2'b00,0));
        run("reset_mid");
        reset = 1'b0;
        op = JMP;
        build(JMP, 0, 0, 0);
        run("after_reset");

        for (int n = 0; n < 60; n++) begin
            op = ops[$urandom_range(0, 7)];
            build(op, $urandom_range(0, 2), $urandom_range(0, 2), rb());
            run($sformatf("rand%0d_op%b", n, op));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
